// File: rtl/multdiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package multdiv_pkg;

  // Default operand/result width; iteration count equals this width.
  localparam int WIDTH_DEF = 32;

  // Iteration counter width: must hold the value WIDTH itself.
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF) + 1;

  // Most negative representable operand at the default width.
  localparam logic [WIDTH_DEF-1:0] MIN_INT = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Per-operation flags captured with the operands at the start edge.
  typedef struct packed {
    logic neg;  // result sign: sign(A) xor sign(B)
    logic dbz;  // divisor was zero
  } op_flags_t;

endpackage

// File: rtl/multdiv_if.sv
// Start/operand and result/status signals between the pipeline and the unit.
// Latency: n/a (wiring only).
// Backpressure: none; the pipeline stalls on busy and never starts while busy.
interface multdiv_if #(
  parameter int WIDTH = multdiv_pkg::WIDTH_DEF
);

  logic             ctrlMult;
  logic             ctrlDiv;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataResult;
  logic             dataException;
  logic             dataRDY;
  logic             busy;

  // Pipeline side: issues operations, consumes results.
  modport master (
    output ctrlMult, ctrlDiv, dataA, dataB,
    input  dataResult, dataException, dataRDY, busy
  );

  // Unit side: accepts operations, produces results.
  modport slave (
    input  ctrlMult, ctrlDiv, dataA, dataB,
    output dataResult, dataException, dataRDY, busy
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0] rem_in,   // partial remainder already shifted in
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  // Trial subtract: keep the difference only when it does not go negative.
  always_comb begin
    q_bit   = (rem_in >= divisor);
    rem_out = q_bit ? (rem_in - divisor) : rem_in;
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide, one bit per cycle.
// Latency: start at edge k -> dataRDY pulse in the cycle after edge k+WIDTH+1.
// Backpressure: busy high while in flight; starts during busy are ignored.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic      clock,
  input  logic      reset_n,
  multdiv_if.slave  bus
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Controller state and iteration counter.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Shared datapath: op holds the multiplicand or divisor magnitude,
  // hi holds the product high half or the partial remainder,
  // lo holds the multiplier bits or the dividend/quotient bits.
  logic [WIDTH:0]   op_q, op_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  op_flags_t        flags_q, flags_d;

  // Registered outputs, updated only when entering DONE.
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  // Operand magnitudes carry one extra bit so that |MIN_INT| is exact.
  logic             sign_a, sign_b;
  logic [WIDTH:0]   mag_a,  mag_b;
  logic             start_ok;

  // Iteration and final fix-up terms.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_in;
  logic [WIDTH:0]   div_rem_out;
  logic             div_q_bit;
  logic [2*WIDTH:0] prod_mag;
  logic [2*WIDTH:0] prod_s;
  logic             mul_ovf;
  logic [WIDTH-1:0] quo_s;
  logic             div_ovf;

  // Operand sign extraction and two's-complement magnitude.
  always_comb begin
    sign_a   = bus.dataA[WIDTH-1];
    sign_b   = bus.dataB[WIDTH-1];
    mag_a    = sign_a ? ({1'b0, ~bus.dataA} + {{WIDTH{1'b0}}, 1'b1})
                      : {1'b0, bus.dataA};
    mag_b    = sign_b ? ({1'b0, ~bus.dataB} + {{WIDTH{1'b0}}, 1'b1})
                      : {1'b0, bus.dataB};
    start_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);
  end

  // Shift-add step: conditionally add the multiplicand into the high half;
  // the caller shifts {sum, lo} right by one. The sum never exceeds W+1 bits
  // because hi stays below 2^WIDTH after every shift.
  always_comb begin
    mul_sum = lo_q[0] ? (hi_q + op_q) : hi_q;
  end

  // Next dividend bit enters the partial remainder from the top of lo.
  assign div_rem_in = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (div_rem_in),
    .divisor (op_q),
    .rem_out (div_rem_out),
    .q_bit   (div_q_bit)
  );

  // Sign fix-up and overflow detection for both operations.
  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod_s   = flags_q.neg ? (-prod_mag) : prod_mag;
    // Representable in WIDTH signed bits iff the top bits down to the
    // result sign bit are all copies of one value.
    mul_ovf  = !((&prod_s[2*WIDTH:WIDTH-1]) || !(|prod_s[2*WIDTH:WIDTH-1]));
    quo_s    = flags_q.neg ? (-lo_q) : lo_q;
    // A positive quotient with the top bit set can only be |MIN_INT|.
    div_ovf  = !flags_q.neg && lo_q[WIDTH-1];
  end

  // Controller: start/accept, per-cycle iteration, DONE entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    flags_d = flags_q;
    res_d   = res_q;
    exc_d   = exc_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE falls back to IDLE unless a new start arrives in that cycle.
        state_d = ST_IDLE;
        if (start_ok && bus.ctrlMult) begin
          state_d     = ST_MULT;
          cnt_d       = '0;
          op_d        = mag_a;
          hi_d        = '0;
          lo_d        = mag_b[WIDTH-1:0];
          flags_d.neg = sign_a ^ sign_b;
          flags_d.dbz = 1'b0;
        end else if (start_ok && bus.ctrlDiv) begin
          state_d     = ST_DIV;
          cnt_d       = '0;
          op_d        = mag_b;
          hi_d        = '0;
          lo_d        = mag_a[WIDTH-1:0];
          flags_d.neg = sign_a ^ sign_b;
          flags_d.dbz = (bus.dataB == '0);
        end
      end

      ST_MULT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          res_d   = prod_s[WIDTH-1:0];
          exc_d   = mul_ovf;
        end else begin
          hi_d  = {1'b0, mul_sum[WIDTH:1]};
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DIV: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          // Divide-by-zero still runs the full iteration count.
          if (flags_q.dbz) begin
            res_d = '0;
            exc_d = 1'b1;
          end else begin
            res_d = quo_s;
            exc_d = div_ovf;
          end
        end else begin
          hi_d  = div_rem_out;
          lo_d  = {lo_q[WIDTH-2:0], div_q_bit};
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flags_q <= flags_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  // Status and result outputs decode directly from registers.
  assign bus.dataResult    = res_q;
  assign bus.dataException = exc_q;
  assign bus.dataRDY       = (state_q == ST_DONE);
  assign bus.busy          = (state_q == ST_MULT) || (state_q == ST_DIV);

endmodule
